// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator: free-running H/V counters with hs/vs/blank decode,
// line/frame strobes and a frame counter, all registered and aligned to DrawX/DrawY.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    // 11-bit bounds so a sync window ending exactly at 1024 still compares correctly
    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [9:0] r_hc;
    logic [9:0] r_vc;
    logic       r_hs;
    logic       r_vs;
    logic       r_blank;
    logic       r_line_start;
    logic       r_frame_start;
    logic [7:0] r_frame_cnt;

    logic       w_h_wrap;
    logic [9:0] w_hc_nxt;
    logic [9:0] w_vc_nxt;
    logic       w_hs_nxt;
    logic       w_vs_nxt;
    logic       w_blank_nxt;
    logic       w_line_nxt;
    logic       w_frame_nxt;
    logic [7:0] w_cnt_nxt;

    // Outputs are decoded from the next-state counters so they land in the same
    // register stage as DrawX/DrawY and stay skew-free.
    always_comb begin
        w_h_wrap = (r_hc == H_LAST);
        w_hc_nxt = w_h_wrap ? '0 : r_hc + 10'd1;
        w_vc_nxt = r_vc;
        if (w_h_wrap) begin
            w_vc_nxt = (r_vc == V_LAST) ? '0 : r_vc + 10'd1;
        end

        w_blank_nxt = ({1'b0, w_hc_nxt} < H_VIS) && ({1'b0, w_vc_nxt} < V_VIS);
        w_hs_nxt    = !(({1'b0, w_hc_nxt} >= H_SYNC_BEG) && ({1'b0, w_hc_nxt} < H_SYNC_END));
        w_vs_nxt    = !(({1'b0, w_vc_nxt} >= V_SYNC_BEG) && ({1'b0, w_vc_nxt} < V_SYNC_END));
        w_line_nxt  = (w_hc_nxt == '0);
        w_frame_nxt = w_line_nxt && (w_vc_nxt == '0);
    end

    // The first frame after reset keeps frame_cnt at 0; later frame starts bump it.
    always_comb begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = r_frame_cnt;
        if (w_frame_nxt && (r_state == ST_RUN)) begin
            w_cnt_nxt = r_frame_cnt + 8'd1;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hc          <= H_LAST;
            r_vc          <= V_LAST;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank       <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_hc          <= w_hc_nxt;
            r_vc          <= w_vc_nxt;
            r_hs          <= w_hs_nxt;
            r_vs          <= w_vs_nxt;
            r_blank       <= w_blank_nxt;
            r_line_start  <= w_line_nxt;
            r_frame_start <= w_frame_nxt;
            r_frame_cnt   <= w_cnt_nxt;
        end
    end

    assign DrawX       = r_hc;
    assign DrawY       = r_vc;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a tiny-raster
// instance for frame-level behaviour, both checked against a position-from-time model.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_b_n;
    logic rst_s_n;

    logic [9:0] b_dx, b_dy, s_dx, s_dy;
    logic       b_hs, b_vs, b_blank, b_ls, b_fs;
    logic       s_hs, s_vs, s_blank, s_ls, s_fs;
    logic [7:0] b_fc, s_fc;

    int checks = 0;
    int errors = 0;

    // Edges since the last reset release minus one; -1 while held in reset.
    int nb = -1;
    int ns = -1;
    always @(posedge clk) begin
        nb <= rst_b_n ? nb + 1 : -1;
        ns <= rst_s_n ? ns + 1 : -1;
    end

    vga_timing_gen u_big (
        .vga_clk    (clk),
        .reset_n    (rst_b_n),
        .DrawX      (b_dx),
        .DrawY      (b_dy),
        .hs         (b_hs),
        .vs         (b_vs),
        .blank      (b_blank),
        .line_start (b_ls),
        .frame_start(b_fs),
        .frame_cnt  (b_fc)
    );

    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
    ) u_small (
        .vga_clk    (clk),
        .reset_n    (rst_s_n),
        .DrawX      (s_dx),
        .DrawY      (s_dy),
        .hs         (s_hs),
        .vs         (s_vs),
        .blank      (s_blank),
        .line_start (s_ls),
        .frame_start(s_fs),
        .frame_cnt  (s_fc)
    );

    typedef struct packed {
        logic [9:0] dx;
        logic [9:0] dy;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    // Raster position is simply elapsed cycles modulo the frame size.
    function automatic obs_t model(input int unsigned hv, hf, hsw, hb,
                                   input int unsigned vv, vf, vsw, vb, input int n);
        obs_t o;
        int unsigned ht, vt, p, f, hc, vc;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (n < 0) begin
            o.dx = 10'(ht - 1); o.dy = 10'(vt - 1);
            o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b0;
            o.ls = 1'b0; o.fs = 1'b0; o.fc = 8'd0;
            return o;
        end
        p  = unsigned'(n) % (ht * vt);
        f  = unsigned'(n) / (ht * vt);
        hc = p % ht;
        vc = p / ht;
        o.dx    = 10'(hc);
        o.dy    = 10'(vc);
        o.blank = (hc < hv) && (vc < vv);
        o.hs    = !((hc >= hv + hf) && (hc < hv + hf + hsw));
        o.vs    = !((vc >= vv + vf) && (vc < vv + vf + vsw));
        o.ls    = (hc == 0);
        o.fs    = (p == 0);
        o.fc    = 8'(f % 256);
        return o;
    endfunction

    function automatic obs_t mb(input int n);
        return model(640, 16, 96, 48, 480, 10, 2, 33, n);
    endfunction

    function automatic obs_t ms(input int n);
        return model(4, 1, 1, 1, 3, 1, 1, 1, n);
    endfunction

    function automatic obs_t obs_big();
        return {b_dx, b_dy, b_hs, b_vs, b_blank, b_ls, b_fs, b_fc};
    endfunction

    function automatic obs_t obs_small();
        return {s_dx, s_dy, s_hs, s_vs, s_blank, s_ls, s_fs, s_fc};
    endfunction

    task automatic test_reset();
        obs_t exp_b;
        rst_b_n = 1'b0;
        rst_s_n = 1'b0;
        repeat (5) @(negedge clk);
        exp_b = '{dx: 10'd799, dy: 10'd524, hs: 1'b1, vs: 1'b1, blank: 1'b0,
                  ls: 1'b0, fs: 1'b0, fc: 8'd0};
        checks++;
        if (obs_big() !== exp_b) begin
            errors++;
            $display("FAIL reset_big: got %h expected %h", obs_big(), exp_b);
        end
        checks++;
        if (obs_small() !== ms(-1)) begin
            errors++;
            $display("FAIL reset_small: got %h expected %h", obs_small(), ms(-1));
        end
    endtask

    task automatic test_first_edges();
        obs_t exp0, exp1;
        rst_b_n = 1'b1;
        rst_s_n = 1'b1;
        exp0 = '{dx: 10'd0, dy: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1,
                 ls: 1'b1, fs: 1'b1, fc: 8'd0};
        exp1 = '{dx: 10'd1, dy: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1,
                 ls: 1'b0, fs: 1'b0, fc: 8'd0};
        @(negedge clk);
        checks++;
        if (obs_big() !== exp0) begin
            errors++;
            $display("FAIL first_edge: got %h expected %h", obs_big(), exp0);
        end
        checks++;
        if (obs_small() !== ms(0)) begin
            errors++;
            $display("FAIL first_edge_small: got %h expected %h", obs_small(), ms(0));
        end
        @(negedge clk);
        checks++;
        if (obs_big() !== exp1) begin
            errors++;
            $display("FAIL second_edge: got %h expected %h", obs_big(), exp1);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        int first_hs = -1;
        int blank_cnt = 0;
        int last_ls = 0;
        while (nb < 3 * 800 - 1) begin
            @(negedge clk);
            checks++;
            if (obs_big() !== mb(nb)) begin
                errors++;
                $display("FAIL line_cycle n=%0d: got %h expected %h", nb, obs_big(), mb(nb));
            end
            if (b_dy == 10'd1) begin
                if (!b_hs) begin
                    hs_low++;
                    if (first_hs < 0) first_hs = int'(b_dx);
                end
                if (b_blank) blank_cnt++;
            end
            if (b_ls) begin
                checks++;
                if (nb - last_ls !== 800) begin
                    errors++;
                    $display("FAIL line_period: got %0d expected 800", nb - last_ls);
                end
                last_ls = nb;
            end
        end
        checks++;
        if (hs_low !== 96) begin
            errors++;
            $display("FAIL hs_width: got %0d expected 96", hs_low);
        end
        checks++;
        if (first_hs !== 656) begin
            errors++;
            $display("FAIL hs_start: got %0d expected 656", first_hs);
        end
        checks++;
        if (blank_cnt !== 640) begin
            errors++;
            $display("FAIL blank_per_line: got %0d expected 640", blank_cnt);
        end
    endtask

    task automatic test_frames_small();
        localparam int FR = 42;
        localparam int NF = 258;
        int vs_cnt[NF];
        int bl_cnt[NF];
        logic [7:0] fcq[$];
        int last_fs = -1;
        logic [7:0] prev_fc = 8'd0;
        obs_t o;
        for (int i = 0; i < NF; i++) begin
            vs_cnt[i] = 0;
            bl_cnt[i] = 0;
        end
        @(negedge clk);
        rst_s_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_s_n = 1'b1;
        for (int k = 0; k < NF * FR; k++) begin
            @(negedge clk);
            o = obs_small();
            checks++;
            if (o !== ms(ns)) begin
                errors++;
                $display("FAIL frame_cycle n=%0d: got %h expected %h", ns, o, ms(ns));
            end
            if (ns >= 0 && ns < NF * FR) begin
                if (!o.vs) vs_cnt[ns / FR]++;
                if (o.blank) bl_cnt[ns / FR]++;
            end
            if (o.fc !== prev_fc) begin
                checks++;
                if (o.fs !== 1'b1) begin
                    errors++;
                    $display("FAIL fc_on_fs n=%0d: got fs=%b expected 1", ns, o.fs);
                end
            end
            prev_fc = o.fc;
            if (o.fs) begin
                fcq.push_back(o.fc);
                if (last_fs >= 0) begin
                    checks++;
                    if (ns - last_fs !== FR) begin
                        errors++;
                        $display("FAIL frame_period: got %0d expected %0d", ns - last_fs, FR);
                    end
                end
                last_fs = ns;
            end
        end
        for (int f = 0; f < NF; f++) begin
            checks++;
            if (vs_cnt[f] !== 7) begin
                errors++;
                $display("FAIL vs_width f=%0d: got %0d expected 7", f, vs_cnt[f]);
            end
            checks++;
            if (bl_cnt[f] !== 12) begin
                errors++;
                $display("FAIL blank_per_frame f=%0d: got %0d expected 12", f, bl_cnt[f]);
            end
        end
        checks++;
        if (fcq.size() !== NF) begin
            errors++;
            $display("FAIL fc_count: got %0d expected %0d", fcq.size(), NF);
        end
        for (int i = 0; i < fcq.size(); i++) begin
            checks++;
            if (fcq[i] !== 8'(i % 256)) begin
                errors++;
                $display("FAIL fc_seq i=%0d: got %0d expected %0d", i, fcq[i], i % 256);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int budget = 0;
        obs_t exp0;
        exp0 = '{dx: 10'd0, dy: 10'd0, hs: 1'b1, vs: 1'b1, blank: 1'b1,
                 ls: 1'b1, fs: 1'b1, fc: 8'd0};
        @(negedge clk);
        while (b_dx !== 10'd300 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (b_dx !== 10'd300) begin
            errors++;
            $display("FAIL midframe_wait: got DrawX=%0d expected 300", b_dx);
        end
        #2 rst_b_n = 1'b0;
        #1;
        checks++;
        if (obs_big() !== mb(-1)) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", obs_big(), mb(-1));
        end
        repeat (3) @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_big() !== exp0) begin
            errors++;
            $display("FAIL restart_first: got %h expected %h", obs_big(), exp0);
        end
        for (int k = 0; k < 900; k++) begin
            @(negedge clk);
            checks++;
            if (obs_big() !== mb(nb)) begin
                errors++;
                $display("FAIL restart_cycle n=%0d: got %h expected %h", nb, obs_big(), mb(nb));
            end
        end
    endtask

    task automatic test_random_resets();
        for (int it = 0; it < 8; it++) begin
            int run = int'($urandom_range(1, 150));
            int hold = int'($urandom_range(1, 3));
            for (int k = 0; k < run; k++) begin
                @(negedge clk);
                checks++;
                if (obs_small() !== ms(ns)) begin
                    errors++;
                    $display("FAIL rand_run n=%0d: got %h expected %h", ns, obs_small(), ms(ns));
                end
            end
            #($urandom_range(1, 3)) rst_s_n = 1'b0;
            #1;
            checks++;
            if (obs_small() !== ms(-1)) begin
                errors++;
                $display("FAIL rand_async: got %h expected %h", obs_small(), ms(-1));
            end
            repeat (hold) @(negedge clk);
            rst_s_n = 1'b1;
        end
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if (obs_small() !== ms(ns)) begin
                errors++;
                $display("FAIL rand_tail n=%0d: got %h expected %h", ns, obs_small(), ms(ns));
            end
        end
    endtask

    initial begin
        rst_b_n = 1'b0;
        rst_s_n = 1'b0;
        test_reset();
        test_first_edges();
        test_line();
        test_frames_small();
        test_reset_midframe();
        test_random_resets();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
